// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: device end of a quad fast-read (0xEB) link with continuous-read
// mode, fetching bytes from a synchronous byte memory and returning them as nibbles.
module qspi_flash_responder #(
    parameter int ADDR_W       = 24,
    parameter int DUMMY_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              qspi_sck,
    input  logic              qspi_cs_n,
    input  logic [3:0]        qspi_io_in,
    output logic [3:0]        qspi_io_out,
    output logic [3:0]        qspi_io_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE} state_t;
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W / 4 - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    logic              sck_r, sck_rr, cs_n_r;
    logic [3:0]        io_r;
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] sr_q, sr_d, addr_q, addr_d;
    logic [3:0]        mode_q, mode_d, io_q, io_d;
    logic [7:0]        buf_q, buf_d, nbuf_q, byte_n;
    logic              cont_q, cont_d, rd_q, rd_d, lat_q, oe_q, oe_d;
    logic              hi_q, hi_d, use_n_q, use_n_d;
    logic              rise, fall;

    assign rise        = sck_r & ~sck_rr;
    assign fall        = ~sck_r & sck_rr;
    assign qspi_io_out = io_q;
    assign qspi_io_oe  = {4{oe_q}};
    assign mem_addr    = addr_q;
    assign mem_rd      = rd_q;
    assign busy        = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        io_d    = io_q;
        buf_d   = (lat_q && state_q == DUMMY) ? mem_data : buf_q;
        cont_d  = cont_q;
        rd_d    = 1'b0;
        oe_d    = oe_q;
        hi_d    = hi_q;
        use_n_d = use_n_q;
        // After the first byte, each high nibble comes from the prefetched next byte
        byte_n  = use_n_q ? nbuf_q : buf_q;
        if (cs_n_r) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = cont_q ? ADDR : CMD;
                    cnt_d   = '0;
                end
                CMD: if (rise) begin
                    sr_d  = {sr_q[ADDR_W-2:0], io_r[0]};
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd7) begin
                        state_d = (sr_d[7:0] == 8'hEB) ? ADDR : IGNORE;
                        cnt_d   = '0;
                    end
                end
                ADDR: if (rise) begin
                    sr_d  = {sr_q[ADDR_W-5:0], io_r};
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == ADDR_LAST) begin
                        state_d = MODE;
                        cnt_d   = '0;
                    end
                end
                MODE: if (rise) begin
                    mode_d = io_r;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == 8'd1) begin
                        cont_d  = mode_q == 4'hA;
                        addr_d  = sr_q;
                        rd_d    = 1'b1;
                        use_n_d = 1'b0;
                        state_d = DUMMY;
                        cnt_d   = '0;
                    end
                end
                DUMMY: if (rise) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == DUMMY_LAST) begin
                        state_d = DATA;
                        hi_d    = 1'b1;
                        cnt_d   = '0;
                    end
                end
                DATA: if (fall) begin
                    oe_d = 1'b1;
                    hi_d = ~hi_q;
                    if (hi_q) begin
                        io_d   = byte_n[7:4];
                        buf_d  = byte_n;
                        addr_d = addr_q + ADDR_W'(1);
                        rd_d   = 1'b1;
                    end else begin
                        io_d    = buf_q[3:0];
                        use_n_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_r   <= 1'b0;
            sck_rr  <= 1'b0;
            cs_n_r  <= 1'b1;
            io_r    <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            addr_q  <= '0;
            mode_q  <= '0;
            io_q    <= '0;
            buf_q   <= '0;
            nbuf_q  <= '0;
            cont_q  <= 1'b0;
            rd_q    <= 1'b0;
            lat_q   <= 1'b0;
            oe_q    <= 1'b0;
            hi_q    <= 1'b0;
            use_n_q <= 1'b0;
        end else begin
            sck_r   <= qspi_sck;
            sck_rr  <= sck_r;
            cs_n_r  <= qspi_cs_n;
            io_r    <= qspi_io_in;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            io_q    <= io_d;
            buf_q   <= buf_d;
            cont_q  <= cont_d;
            rd_q    <= rd_d;
            lat_q   <= rd_q;
            oe_q    <= oe_d;
            hi_q    <= hi_d;
            use_n_q <= use_n_d;
            if (lat_q && state_q != DUMMY) nbuf_q <= mem_data;
        end
    end
endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb_qspi_flash_responder: drives quad-read transactions as the initiator and compares
// returned nibbles, memory reads and control timing against a transaction-level model.
module tb_qspi_flash_responder;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sck = 1'b0;
    logic          cs_n = 1'b1;
    logic [3:0]    io_in = '0;
    logic [3:0]    io_out, io_oe;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, busy;
    logic [7:0]    mem_data = '0;
    int            checks = 0, failures = 0;
    int            hi_clk = 2, lo_clk = 2;
    bit            model_cont = 1'b0;
    logic [AW-1:0] rd_log[$];

    always #5 clk = ~clk;

    qspi_flash_responder #(.ADDR_W(AW), .DUMMY_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .qspi_sck(sck), .qspi_cs_n(cs_n),
        .qspi_io_in(io_in), .qspi_io_out(io_out), .qspi_io_oe(io_oe),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .busy(busy)
    );

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data <= mem_byte(mem_addr);
            rd_log.push_back(mem_addr);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One sck period: fall, drive io, hold low, sample responder, rise, hold high.
    task automatic sck_cycle(input logic [3:0] drv, output logic [3:0] nib, output logic [3:0] oe);
        @(negedge clk);
        sck = 1'b0;
        io_in = drv;
        repeat (lo_clk) @(negedge clk);
        nib = io_out;
        oe = io_oe;
        sck = 1'b1;
        repeat (hi_clk - 1) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [AW-1:0] addr, input logic [7:0] mode,
                        input int nnib, input string tag, input bit rst_end);
        logic [3:0]    nib, oe;
        logic [AW-1:0] a;
        logic [7:0]    b;
        logic [AW-1:0] exp_rd[$];
        int            oe_bad, bad;
        bit            send;
        oe_bad = 0;
        bad = 0;
        send = !model_cont;
        rd_log.delete();
        @(negedge clk);
        cs_n = 1'b0;
        if (send)
            for (int i = 7; i >= 0; i--) begin
                sck_cycle({3'($urandom), cmd[i]}, nib, oe);
                oe_bad += int'(oe != 4'h0);
            end
        if (send && cmd != 8'hEB) begin
            repeat (40) begin
                sck_cycle(4'($urandom), nib, oe);
                oe_bad += int'(oe != 4'h0);
            end
        end else begin
            for (int i = AW / 4 - 1; i >= 0; i--) begin
                sck_cycle(addr[i*4 +: 4], nib, oe);
                oe_bad += int'(oe != 4'h0);
            end
            sck_cycle(mode[7:4], nib, oe);
            oe_bad += int'(oe != 4'h0);
            sck_cycle(mode[3:0], nib, oe);
            oe_bad += int'(oe != 4'h0);
            repeat (4) begin
                sck_cycle(4'($urandom), nib, oe);
                oe_bad += int'(oe != 4'h0);
            end
            for (int k = 0; k < nnib; k++) begin
                a = addr + AW'(k / 2);
                b = mem_byte(a);
                sck_cycle(4'($urandom), nib, oe);
                check({tag, "_nib"}, 32'(nib), 32'((k % 2 == 0) ? b[7:4] : b[3:0]));
                check({tag, "_oe_data"}, 32'(oe), 32'hF);
            end
            model_cont = mode[7:4] == 4'hA;
            for (int i = 0; i <= (nnib + 1) / 2; i++) exp_rd.push_back(addr + AW'(i));
        end
        check({tag, "_oe_pre_data"}, 32'(oe_bad), 32'h0);
        if (rst_end) begin
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check({tag, "_rst_ctl"}, 32'({io_out, io_oe, mem_rd, busy}), 32'h0);
            check({tag, "_rst_addr"}, 32'(mem_addr), 32'h0);
            cs_n = 1'b1;
            repeat (6) begin
                sck_cycle(4'($urandom), nib, oe);
                bad += int'(oe != 4'h0 || busy || mem_rd);
            end
            rst_n = 1'b1;
            repeat (6) begin
                sck_cycle(4'($urandom), nib, oe);
                bad += int'(oe != 4'h0 || busy || mem_rd);
            end
            check({tag, "_rst_idle"}, 32'(bad), 32'h0);
            model_cont = 1'b0;
            @(negedge clk);
            sck = 1'b0;
        end else begin
            @(negedge clk);
            cs_n = 1'b1;
            sck = 1'b0;
            @(posedge clk);
            #1 check({tag, "_busy_hold"}, 32'(busy), 32'h1);
            @(posedge clk);
            #1 check({tag, "_busy_off"}, 32'(busy), 32'h0);
            check({tag, "_oe_off"}, 32'(io_oe), 32'h0);
            check({tag, "_rd_count"}, 32'(rd_log.size()), 32'(exp_rd.size()));
            for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
                check({tag, "_rd_addr"}, 32'(rd_log[i]), 32'(exp_rd[i]));
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0]    cmd, mode;
        logic [AW-1:0] addr;
        repeat (3) @(negedge clk);
        check("reset_io", 32'(io_out), 32'h0);
        check("reset_oe", 32'(io_oe), 32'h0);
        check("reset_addr", 32'(mem_addr), 32'h0);
        check("reset_rd", 32'(mem_rd), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        xfer(8'hEB, 24'h000010, 8'h00, 4, "basic", 1'b0);
        xfer(8'h03, 24'h000000, 8'h00, 0, "badcmd", 1'b0);
        xfer(8'hEB, 24'h000100, 8'hA0, 2, "cont1", 1'b0);
        xfer(8'hEB, 24'hFFFFFE, 8'hA5, 6, "cont_wrap", 1'b0);
        xfer(8'hEB, 24'h000040, 8'h00, 2, "cont_exit", 1'b0);
        xfer(8'hEB, 24'h000050, 8'h00, 2, "cmd_again", 1'b0);
        xfer(8'hEB, 24'h000080, 8'h00, 3, "abort", 1'b0);
        xfer(8'hEB, 24'h000020, 8'h00, 4, "after_abort", 1'b0);
        xfer(8'hEB, 24'h123456, 8'hA0, 4, "rst_mid", 1'b1);
        xfer(8'hEB, 24'h000033, 8'h00, 2, "post_rst", 1'b0);
        for (int t = 0; t < 10; t++) begin
            hi_clk = $urandom_range(1, 3);
            lo_clk = $urandom_range(2, 3);
            cmd = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hEB;
            addr = AW'($urandom);
            mode = ($urandom_range(0, 1) == 1) ? {4'hA, 4'($urandom)} : 8'($urandom);
            xfer(cmd, addr, mode, $urandom_range(1, 8), "rand", 1'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
